uart_tx_drain: RTL and testbench

- 8N1 UART transmitter that sits directly downstream of the console FIFO and drains it onto the serial line.
- Watches the FIFO `empty` flag and reads bytes from its registered `data_out`.
- Pulses the FIFO `advance_read_ptr` exactly once per byte it consumes.
- Drives the idle-high `tx` pin of the console output.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx_drain.sv | 109 ++++++++++
 tb/tb_uart_tx_drain.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the console UART blocks.
//   uart_state_t         transmitter FSM states
//   UART_IDLE/UART_START line levels for the idle/stop and start conditions
//   DEFAULT_CLKS_PER_BIT 12 MHz / 115200 baud
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk      system clock
//   rst      asynchronous, active-high reset
//   restart  hold the counter at 0; the first bit period starts when released
//   bit_done one-cycle pulse on the last cycle of every bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_done = (count == LAST) && !restart;

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that drains the console FIFO onto the serial line.
//   clk        system clock
//   rst        asynchronous, active-high reset
//   tx_en      permit starting a new frame (looked at only in IDLE)
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO registered data_out, valid one cycle after empty falls
//   fifo_rd    FIFO advance_read_ptr, one-cycle pulse per consumed byte
//   tx         serial line, idle high, registered
//   busy       high from FETCH through the end of STOP
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 busy
);

    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IW-1:0]        bit_idx;
    logic                 bit_done;
    logic                 baud_restart;

    // Holding the timer in IDLE and FETCH means it is at 0 on the first
    // cycle of START, so the start bit is exactly one full bit period.
    assign baud_restart = (state == IDLE) || (state == FETCH);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (baud_restart),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= UART_IDLE;
            fifo_rd   <= 1'b0;
            busy      <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            // Read strobe defaults low; only the IDLE->FETCH transition raises
            // it, which makes it a single-cycle pulse aligned with FETCH.
            fifo_rd <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= UART_IDLE;
                    busy <= 1'b0;
                    if (tx_en && !fifo_empty) begin
                        state   <= FETCH;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    // data_out is valid now, one cycle after empty fell.
                    shift_reg <= fifo_data;
                    tx        <= UART_START;
                    state     <= START;
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shift_reg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            tx    <= UART_IDLE;
                            state <= STOP;
                        end else begin
                            // Next bit is shift_reg[1] before this shift lands.
                            tx      <= shift_reg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain with a 16-deep registered-output FIFO
// model upstream. A line monitor decodes each frame and compares it against
// a scoreboard of expected bytes pushed by the stimulus.
`timescale 1ns/1ps
module tb_uart_tx_drain;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx_drain #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy)
    );

    // ---------------- FIFO model (DEPTH=16, registered data_out) ----------
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] mem [16];
    logic [3:0] rp = 4'd0;
    logic [3:0] wp = 4'd0;
    int         count = 0;

    assign fifo_empty = (count == 0);

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 4'd1;
        end
        if (fifo_rd && count != 0) rp <= rp + 4'd1;
        count     <= count + (wr_en ? 1 : 0) - ((fifo_rd && count != 0) ? 1 : 0);
        fifo_data <= mem[rp];
    end

    // ---------------- bookkeeping ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         pulses  = 0;
    int         viol    = 0;
    int         frames_done = 0;
    logic       rd_prev = 1'b0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int st(input int i);
        return (i < start_q.size()) ? start_q[i] : -1000;
    endfunction

    // Read-strobe protocol: never while empty, never two cycles in a row.
    always @(negedge clk) begin
        if (fifo_rd) begin
            pulses++;
            if (fifo_empty) viol++;
            if (rd_prev) viol++;
        end
        rd_prev = fifo_rd;
    end

    // ---------------- line monitor / scoreboard ----------------
    initial begin : monitor
        logic             prev_tx;
        logic             aborted;
        logic [FRAME-1:0] wave;
        logic [FRAME-1:0] busy_v;
        logic [FRAME-1:0] exp_w;
        logic [9:0]       lv;
        logic [7:0]       got_b;
        logic [7:0]       exp_b;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_tx = 1'b1;
                continue;
            end
            if (prev_tx && !tx) begin
                start_q.push_back(cyc);
                wave      = '0;
                busy_v    = '0;
                aborted   = 1'b0;
                wave[0]   = tx;
                busy_v[0] = busy;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    wave[i]   = tx;
                    busy_v[i] = busy;
                end
                if (!aborted) begin
                    @(negedge clk);
                    check("scoreboard_has_entry", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        lv    = {1'b1, exp_b, 1'b0};
                        for (int i = 0; i < FRAME; i++) exp_w[i] = lv[i / CPB];
                        for (int k = 0; k < 8; k++) got_b[k] = wave[(k + 1) * CPB + CPB / 2];
                        check("frame_wave", wave, exp_w);
                        check("frame_byte", got_b, exp_b);
                        check("frame_busy", busy_v, {FRAME{1'b1}});
                        check("post_frame_idle", {busy, tx}, 2'b01);
                    end
                    frames_done++;
                end
                prev_tx = 1'b1;
            end else begin
                prev_tx = tx;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_byte(input logic [7:0] b, input bit expect_out, output int n);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_out) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
        n     = cyc;  // first cycle with the FIFO non-empty
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (frames_done >= target), 1);
    endtask

    task automatic wait_start(input int target, input int budget, input string name);
        int n = 0;
        while (start_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (start_q.size() >= target), 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, n2, k, s, p0, fr, bad;
        rst     = 1'b1;
        tx_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        fr      = 0;

        // Reset must act before any clock edge.
        #2;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_rd", fifo_rd, 0);
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        tx_en = 1'b1;

        // Enabled but FIFO empty: line stays idle.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) bad++;
        end
        check("idle_empty_quiet", bad, 0);

        // Single byte 0xA5.
        start_q.delete();
        p0 = pulses;
        push_byte(8'hA5, 1, n);
        fr += 1;
        wait_frames(fr, 200, "a5_frame_seen");
        check("a5_latency", st(0) - n, 2);
        check("a5_rd_pulses", pulses - p0, 1);

        // Back-to-back 0x00, 0xFF, 0x55.
        start_q.delete();
        p0 = pulses;
        push_byte(8'h00, 1, n);
        push_byte(8'hFF, 1, n2);
        push_byte(8'h55, 1, n2);
        fr += 3;
        wait_frames(fr, 400, "b2b_frames_seen");
        check("b2b_latency", st(0) - n, 2);
        check("b2b_gap1", st(1) - (st(0) + FRAME), 2);
        check("b2b_gap2", st(2) - (st(1) + FRAME), 2);
        check("b2b_rd_pulses", pulses - p0, 3);
        repeat (2) @(negedge clk);
        check("b2b_fifo_empty", fifo_empty, 1);

        // Disabled with 0x41 queued, then enabled.
        tx_en = 1'b0;
        start_q.delete();
        p0 = pulses;
        push_byte(8'h41, 1, n);
        repeat (50) @(negedge clk);
        check("disabled_no_start", start_q.size(), 0);
        check("disabled_no_rd", pulses - p0, 0);
        check("disabled_busy", busy, 0);
        @(negedge clk);
        tx_en = 1'b1;
        k     = cyc;
        fr += 1;
        wait_frames(fr, 200, "41_frame_seen");
        check("enable_latency", st(0) - k, 2);

        // Drop tx_en during DATA of 0x3C with 0x7E queued.
        start_q.delete();
        p0 = pulses;
        push_byte(8'h3C, 1, n);
        push_byte(8'h7E, 1, n2);
        wait_start(1, 50, "3c_started");
        repeat (20) @(negedge clk);
        tx_en = 1'b0;
        fr += 1;
        wait_frames(fr, 100, "3c_frame_seen");
        repeat (30) @(negedge clk);
        check("hold_no_start", start_q.size(), 1);
        check("hold_rd_pulses", pulses - p0, 1);
        check("hold_fifo_nonempty", fifo_empty, 0);
        @(negedge clk);
        tx_en = 1'b1;
        k     = cyc;
        fr += 1;
        wait_frames(fr, 100, "7e_frame_seen");
        check("7e_latency", st(1) - k, 2);

        // Reset in data bit 3 of 0xC3 (bit value 0); 0xD2 queued behind it.
        start_q.delete();
        push_byte(8'hC3, 0, n);
        push_byte(8'hD2, 1, n2);
        wait_start(1, 50, "c3_started");
        s = st(0);
        while (cyc < s + 17) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_tx_async", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd", fifo_rd, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_idle", {busy, tx, fifo_rd}, 3'b010);
        rst = 1'b0;
        fr += 1;
        wait_frames(fr, 150, "d2_frame_seen");

        repeat (5) @(negedge clk);
        check("protocol_violations", viol, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
